// File: rtl/ifm_axis_out.sv
// Receive output stage: drains one complete frame at a time from the ctrl/good FIFOs,
// emitting control words on the rxs stream, then payload on the rxd stream.
module ifm_axis_out #(
    parameter int unsigned C_CTRL_WORDS = 6,
    parameter int unsigned C_FCNT_W     = 32
) (
    input  logic                s2mm_clk,
    input  logic                s2mm_resetn,
    input  logic [72:0]         good_fifo_rdata,
    input  logic                good_fifo_empty,
    output logic                good_fifo_rden,
    input  logic [36:0]         ctrl_fifo_rdata,
    input  logic                ctrl_fifo_empty,
    output logic                ctrl_fifo_rden,
    output logic [63:0]         m_axis_rxd_tdata,
    output logic [7:0]          m_axis_rxd_tkeep,
    output logic                m_axis_rxd_tlast,
    output logic                m_axis_rxd_tvalid,
    input  logic                m_axis_rxd_tready,
    output logic [31:0]         m_axis_rxs_tdata,
    output logic [3:0]          m_axis_rxs_tkeep,
    output logic                m_axis_rxs_tlast,
    output logic                m_axis_rxs_tvalid,
    input  logic                m_axis_rxs_tready,
    output logic [C_FCNT_W-1:0] frame_cnt,
    output logic                ctrl_err,
    output logic [3:0]          ifm_axis_dbg
);

    localparam int unsigned       WCNT_W    = $clog2(C_CTRL_WORDS) + 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(C_CTRL_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CTRL = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic [C_FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                  err_q, err_d;

    logic [63:0]           rxd_data_q;
    logic [7:0]            rxd_keep_q;
    logic                  rxd_last_q, rxd_valid_q;
    logic [31:0]           rxs_data_q;
    logic [3:0]            rxs_keep_q;
    logic                  rxs_last_q, rxs_valid_q;

    logic                  load_rxs, load_rxd, force_last;

    // State register
    always_ff @(posedge s2mm_clk) begin
        if (!s2mm_resetn) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            fcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            fcnt_q  <= fcnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        fcnt_d  = fcnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (!ctrl_fifo_empty) begin
                    state_d = CTRL;
                    wcnt_d  = '0;
                end
            end
            CTRL: begin
                if (load_rxs) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    if (ctrl_fifo_rdata[36]) begin
                        state_d = DATA;
                    end else if (force_last) begin
                        state_d = DATA;
                        err_d   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (load_rxd && good_fifo_rdata[72]) state_d = DONE;
            end
            DONE: begin
                // Frame counts only once both final beats have left the output registers.
                if (!rxs_valid_q && !rxd_valid_q) begin
                    fcnt_d  = fcnt_q + C_FCNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / pop logic
    always_comb begin
        load_rxs   = 1'b0;
        load_rxd   = 1'b0;
        force_last = (wcnt_q == WCNT_LAST);
        if (s2mm_resetn) begin
            load_rxs = (state_q == CTRL) && !ctrl_fifo_empty && (!rxs_valid_q || m_axis_rxs_tready);
            load_rxd = (state_q == DATA) && !good_fifo_empty && (!rxd_valid_q || m_axis_rxd_tready);
        end
    end

    assign ctrl_fifo_rden = load_rxs;
    assign good_fifo_rden = load_rxd;

    always_ff @(posedge s2mm_clk) begin
        if (!s2mm_resetn) begin
            rxs_data_q  <= '0;
            rxs_keep_q  <= '0;
            rxs_last_q  <= 1'b0;
            rxs_valid_q <= 1'b0;
            rxd_data_q  <= '0;
            rxd_keep_q  <= '0;
            rxd_last_q  <= 1'b0;
            rxd_valid_q <= 1'b0;
        end else begin
            if (load_rxs) begin
                rxs_data_q  <= ctrl_fifo_rdata[31:0];
                rxs_keep_q  <= ctrl_fifo_rdata[35:32];
                rxs_last_q  <= ctrl_fifo_rdata[36] || force_last;
                rxs_valid_q <= 1'b1;
            end else if (m_axis_rxs_tready && rxs_valid_q) begin
                rxs_valid_q <= 1'b0;
            end
            if (load_rxd) begin
                rxd_data_q  <= good_fifo_rdata[63:0];
                rxd_keep_q  <= good_fifo_rdata[71:64];
                rxd_last_q  <= good_fifo_rdata[72];
                rxd_valid_q <= 1'b1;
            end else if (m_axis_rxd_tready && rxd_valid_q) begin
                rxd_valid_q <= 1'b0;
            end
        end
    end

    assign m_axis_rxs_tdata  = rxs_data_q;
    assign m_axis_rxs_tkeep  = rxs_keep_q;
    assign m_axis_rxs_tlast  = rxs_last_q;
    assign m_axis_rxs_tvalid = rxs_valid_q;
    assign m_axis_rxd_tdata  = rxd_data_q;
    assign m_axis_rxd_tkeep  = rxd_keep_q;
    assign m_axis_rxd_tlast  = rxd_last_q;
    assign m_axis_rxd_tvalid = rxd_valid_q;
    assign frame_cnt         = fcnt_q;
    assign ctrl_err          = err_q;
    assign ifm_axis_dbg      = {ctrl_fifo_empty, good_fifo_empty, state_q};

endmodule

// File: tb/tb_ifm_axis_out.sv
// Bench for ifm_axis_out: FWFT FIFO models feed random frames; delivered beats
// are compared against per-frame expectations built when each frame is queued.
module tb_ifm_axis_out;

    localparam int unsigned CW = 6;

    logic        clk = 1'b0;
    logic        resetn;
    logic [72:0] good_fifo_rdata;
    logic        good_fifo_empty, good_fifo_rden;
    logic [36:0] ctrl_fifo_rdata;
    logic        ctrl_fifo_empty, ctrl_fifo_rden;
    logic [63:0] m_axis_rxd_tdata;
    logic [7:0]  m_axis_rxd_tkeep;
    logic        m_axis_rxd_tlast, m_axis_rxd_tvalid, m_axis_rxd_tready;
    logic [31:0] m_axis_rxs_tdata;
    logic [3:0]  m_axis_rxs_tkeep;
    logic        m_axis_rxs_tlast, m_axis_rxs_tvalid, m_axis_rxs_tready;
    logic [31:0] frame_cnt;
    logic        ctrl_err;
    logic [3:0]  ifm_axis_dbg;

    always #5 clk = ~clk;

    ifm_axis_out #(.C_CTRL_WORDS(CW), .C_FCNT_W(32)) dut (
        .s2mm_clk         (clk),
        .s2mm_resetn      (resetn),
        .good_fifo_rdata  (good_fifo_rdata),
        .good_fifo_empty  (good_fifo_empty),
        .good_fifo_rden   (good_fifo_rden),
        .ctrl_fifo_rdata  (ctrl_fifo_rdata),
        .ctrl_fifo_empty  (ctrl_fifo_empty),
        .ctrl_fifo_rden   (ctrl_fifo_rden),
        .m_axis_rxd_tdata (m_axis_rxd_tdata),
        .m_axis_rxd_tkeep (m_axis_rxd_tkeep),
        .m_axis_rxd_tlast (m_axis_rxd_tlast),
        .m_axis_rxd_tvalid(m_axis_rxd_tvalid),
        .m_axis_rxd_tready(m_axis_rxd_tready),
        .m_axis_rxs_tdata (m_axis_rxs_tdata),
        .m_axis_rxs_tkeep (m_axis_rxs_tkeep),
        .m_axis_rxs_tlast (m_axis_rxs_tlast),
        .m_axis_rxs_tvalid(m_axis_rxs_tvalid),
        .m_axis_rxs_tready(m_axis_rxs_tready),
        .frame_cnt        (frame_cnt),
        .ctrl_err         (ctrl_err),
        .ifm_axis_dbg     (ifm_axis_dbg)
    );

    logic [36:0] cq[$], exp_s[$], got_s[$];
    logic [72:0] gq[$], exp_d[$], got_d[$];
    logic [36:0] fixed_ctrl[6];
    bit          hold_c, hold_g, rxd_toggle;
    int          rxs_low;
    int          n_tests, n_fail, cyc;
    int          cw_idx, frames_begun, gd_eofs, rxd_lasts, c_pops, g_pops;
    int          exp_fcnt;
    logic        exp_err;
    bit          prev_s_stall, prev_d_stall;
    logic [36:0] prev_s;
    logic [72:0] prev_d;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive();
        ctrl_fifo_empty   = hold_c || (cq.size() == 0);
        ctrl_fifo_rdata   = (cq.size() != 0) ? cq[0] : '0;
        good_fifo_empty   = hold_g || (gq.size() == 0);
        good_fifo_rdata   = (gq.size() != 0) ? gq[0] : '0;
        m_axis_rxd_tready = rxd_toggle ? cyc[0] : 1'b1;
        m_axis_rxs_tready = (rxs_low == 0);
    endtask

    // One clock: sample mid-cycle, check handshakes and pop rules, then advance FIFOs.
    task automatic tick();
        bit          pc, pg;
        logic [36:0] cw;
        logic [72:0] gw;
        #1;
        pc = ctrl_fifo_rden;
        pg = good_fifo_rden;
        chk("rxd_rden_stall", good_fifo_rden && m_axis_rxd_tvalid && !m_axis_rxd_tready, 0);
        chk("rxs_rden_stall", ctrl_fifo_rden && m_axis_rxs_tvalid && !m_axis_rxs_tready, 0);
        chk("ctrl_pop_empty", ctrl_fifo_rden && ctrl_fifo_empty, 0);
        chk("good_pop_empty", good_fifo_rden && good_fifo_empty, 0);
        if (prev_d_stall)
            chk("rxd_hold", {m_axis_rxd_tvalid, m_axis_rxd_tlast, m_axis_rxd_tkeep, m_axis_rxd_tdata}, {1'b1, prev_d});
        if (prev_s_stall)
            chk("rxs_hold", {m_axis_rxs_tvalid, m_axis_rxs_tlast, m_axis_rxs_tkeep, m_axis_rxs_tdata}, {1'b1, prev_s});
        prev_d_stall = resetn && m_axis_rxd_tvalid && !m_axis_rxd_tready;
        prev_s_stall = resetn && m_axis_rxs_tvalid && !m_axis_rxs_tready;
        prev_d = {m_axis_rxd_tlast, m_axis_rxd_tkeep, m_axis_rxd_tdata};
        prev_s = {m_axis_rxs_tlast, m_axis_rxs_tkeep, m_axis_rxs_tdata};
        if (m_axis_rxd_tvalid && m_axis_rxd_tready) begin
            got_d.push_back(prev_d);
            if (m_axis_rxd_tlast) rxd_lasts++;
        end
        if (m_axis_rxs_tvalid && m_axis_rxs_tready) got_s.push_back(prev_s);
        if (pc && cq.size() != 0) begin
            cw = cq[0];
            if (cw_idx == 0) begin
                chk("ctrl_pop_after_prev_frame", frames_begun, rxd_lasts);
                frames_begun++;
            end
            cw_idx++;
            if (cw[36] || cw_idx == CW) cw_idx = 0;
            c_pops++;
        end
        if (pg && gq.size() != 0) begin
            gw = gq[0];
            chk("rxs_before_rxd", {cw_idx == 0, frames_begun == gd_eofs + 1}, 2'b11);
            if (gw[72]) gd_eofs++;
            g_pops++;
        end
        @(posedge clk);
        #1;
        if (pc && cq.size() != 0) void'(cq.pop_front());
        if (pg && gq.size() != 0) void'(gq.pop_front());
        cyc++;
        if (rxs_low > 0) rxs_low--;
        drive();
        @(negedge clk);
    endtask

    task automatic add_frame(input int nc, input bit with_last, input int nd, input logic [7:0] lk, input bit fixed);
        logic [36:0] w;
        logic [72:0] g;
        for (int i = 0; i < nc; i++) begin
            if (fixed) w = fixed_ctrl[i];
            else w = {with_last && (i == nc - 1), 4'($urandom_range(0, 15)), 32'($urandom)};
            cq.push_back(w);
            exp_s.push_back({w[36] || (i == CW - 1), w[35:0]});
            if (i == CW - 1 && !w[36]) exp_err = 1'b1;
        end
        for (int j = 0; j < nd; j++) begin
            g = {j == nd - 1, (j == nd - 1) ? lk : 8'hFF, 32'($urandom), 32'($urandom)};
            gq.push_back(g);
            exp_d.push_back(g);
        end
        exp_fcnt++;
        drive();
    endtask

    task automatic wait_lasts(input string tag, input int target, input int budget);
        int n = 0;
        while (rxd_lasts < target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, rxd_lasts, target);
    endtask

    task automatic wait_pops(input string tag, input bit good, input int target, input int budget);
        int n = 0;
        while (((good ? g_pops : c_pops) < target) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, good ? g_pops : c_pops, target);
    endtask

    task automatic check_streams(input string tag);
        chk({tag, "_rxs_count"}, got_s.size(), exp_s.size());
        chk({tag, "_rxd_count"}, got_d.size(), exp_d.size());
        for (int i = 0; i < got_s.size() && i < exp_s.size(); i++)
            chk({tag, "_rxs_beat"}, got_s[i], exp_s[i]);
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++)
            chk({tag, "_rxd_beat"}, got_d[i], exp_d[i]);
        got_s.delete(); exp_s.delete(); got_d.delete(); exp_d.delete();
    endtask

    initial begin
        int base;
        fixed_ctrl[0] = {1'b0, 4'hF, 32'h5000_0000};
        fixed_ctrl[1] = {1'b0, 4'hF, 32'h0000_0000};
        fixed_ctrl[2] = {1'b0, 4'hF, 32'h0000_0000};
        fixed_ctrl[3] = {1'b0, 4'hF, 32'h0000_0080};
        fixed_ctrl[4] = {1'b0, 4'hF, 32'h0000_0000};
        fixed_ctrl[5] = {1'b1, 4'hF, 32'h0000_003C};
        resetn = 1'b0;
        hold_c = 0; hold_g = 0; rxd_toggle = 0; rxs_low = 0;
        exp_fcnt = 0; exp_err = 1'b0;
        drive();
        @(negedge clk);
        tick(); tick();
        chk("rst_rxd", {m_axis_rxd_tdata, m_axis_rxd_tkeep, m_axis_rxd_tlast, m_axis_rxd_tvalid}, 0);
        chk("rst_rxs", {m_axis_rxs_tdata, m_axis_rxs_tkeep, m_axis_rxs_tlast, m_axis_rxs_tvalid}, 0);
        chk("rst_misc", {frame_cnt, ctrl_err, ifm_axis_dbg[1:0], ctrl_fifo_rden, good_fifo_rden}, 0);
        resetn = 1'b1;

        // Single frame, full ready
        add_frame(6, 1, 8, 8'h0F, 1);
        wait_lasts("single_timeout", 1, 200);
        chk("single_fcnt_not_yet", frame_cnt, exp_fcnt - 1);
        tick();
        chk("single_fcnt_two_cycles", frame_cnt, exp_fcnt);
        chk("single_err", ctrl_err, 0);
        check_streams("single");

        // Backpressure on both channels
        rxd_toggle = 1; rxs_low = 5;
        add_frame(6, 1, 8, 8'h0F, 0);
        wait_lasts("bp_timeout", 2, 400);
        rxd_toggle = 0; drive();
        repeat (3) tick();
        chk("bp_fcnt", frame_cnt, exp_fcnt);
        check_streams("bp");

        // Control packet without last
        add_frame(6, 0, 5, 8'h01, 0);
        wait_lasts("err_timeout", 3, 200);
        repeat (3) tick();
        chk("err_flag", ctrl_err, exp_err);
        chk("err_fcnt", frame_cnt, exp_fcnt);
        check_streams("err");

        // Starved FIFOs
        add_frame(6, 1, 12, 8'h3F, 0);
        base = c_pops;
        wait_pops("starve_c_timeout", 0, base + 3, 200);
        hold_c = 1; drive();
        repeat (5) tick();
        chk("starve_ctrl_state", {ifm_axis_dbg[1:0], m_axis_rxs_tvalid}, {2'd1, 1'b0});
        repeat (2) tick();
        hold_c = 0; drive();
        base = g_pops;
        wait_pops("starve_g_timeout", 1, base + 4, 200);
        hold_g = 1; drive();
        repeat (5) tick();
        chk("starve_data_state", {ifm_axis_dbg[1:0], m_axis_rxd_tvalid}, {2'd2, 1'b0});
        repeat (5) tick();
        hold_g = 0; drive();
        wait_lasts("starve_timeout", 4, 300);
        repeat (3) tick();
        chk("starve_fcnt", frame_cnt, exp_fcnt);
        check_streams("starve");

        // Back-to-back frames preloaded
        for (int f = 0; f < 3; f++)
            add_frame($urandom_range(1, CW), 1, $urandom_range(1, 6), 8'($urandom_range(1, 255)), 0);
        wait_lasts("b2b_timeout", 7, 600);
        repeat (3) tick();
        chk("b2b_fcnt", frame_cnt, exp_fcnt);
        check_streams("b2b");

        // Reset in the middle of the payload
        add_frame(6, 1, 8, 8'hFF, 0);
        base = 0;
        while (got_d.size() < 4 && base < 200) begin
            tick();
            base++;
        end
        chk("rstmid_reach_beat4", got_d.size(), 4);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        cq.delete(); gq.delete();
        got_s.delete(); exp_s.delete(); got_d.delete(); exp_d.delete();
        cw_idx = 0; frames_begun = 0; gd_eofs = 0; rxd_lasts = 0;
        exp_fcnt = 0; exp_err = 1'b0;
        prev_s_stall = 0; prev_d_stall = 0;
        drive();
        chk("rstmid_valids", {m_axis_rxd_tvalid, m_axis_rxs_tvalid}, 0);
        chk("rstmid_state", {frame_cnt, ctrl_err, ifm_axis_dbg[1:0]}, 0);
        add_frame(4, 1, 6, 8'h07, 0);
        wait_lasts("fresh_timeout", 1, 200);
        repeat (3) tick();
        chk("fresh_fcnt", frame_cnt, exp_fcnt);
        check_streams("fresh");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
